seq_divider: RTL and testbench

- Multi-cycle shift-subtract (restoring) divider; the inverse companion to the team's sequential Booth multiplier.
- Takes WIDTH-bit dividend and divisor; produces quotient and remainder after a fixed WIDTH+2 cycle latency.
- Sits beside the multiplier in the arithmetic datapath and uses the same start/busy style of control.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/trial_subtractor.sv | 20 ++
 rtl/seq_divider.sv | 167 ++++++++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Build with SEQ_DIVIDER_SIGNED_EN for two's-complement operation.
package divider_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational trial subtraction R - D for one restoring step.
// nonneg is high when the shifted partial remainder covers D.
module trial_subtractor
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH:0]   diff,
    output logic             nonneg
);

    logic [WIDTH+1:0] wide;

    assign wide   = {1'b0, rem} - {2'b00, den};
    assign diff   = wide[WIDTH:0];
    assign nonneg = ~wide[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle shift-subtract divider, WIDTH+2 cycle latency.
// SEQ_DIVIDER_SIGNED_EN selects signed operands; default is unsigned.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] qs;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] n_raw;
    logic             zero_d;

    logic [WIDTH-1:0] abs_n;
    logic [WIDTH-1:0] abs_d;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             nonneg;
    logic             accept;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic sgn_n;
    logic sgn_q;
    logic min_neg;
    logic ovf_q;

    assign abs_n    = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_d    = divisor[WIDTH-1] ? -divisor : divisor;
    assign overflow = ovf_q;
`else
    assign abs_n    = dividend;
    assign abs_d    = divisor;
    assign overflow = 1'b0;
`endif

    assign accept = (state_q == IDLE) && start;
    assign r_sh   = {r[WIDTH-1:0], qs[WIDTH-1]};

    trial_subtractor #(
        .WIDTH (WIDTH)
    ) u_trial (
        .rem    (r_sh),
        .den    (d),
        .diff   (diff),
        .nonneg (nonneg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (cnt == LAST) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state_q == ITER): busy = 1'b1;
            (state_q == FIX):  busy = 1'b1;
            (state_q == DONE): done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qs          <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            n_raw       <= '0;
            zero_d      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn_n       <= 1'b0;
            sgn_q       <= 1'b0;
            min_neg     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else if (accept) begin
            qs     <= abs_n;
            d      <= abs_d;
            r      <= '0;
            cnt    <= '0;
            n_raw  <= dividend;
            zero_d <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgn_n   <= dividend[WIDTH-1];
            sgn_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            min_neg <= (dividend == MOST_NEG) && (divisor == '1);
`endif
        end else if (state_q == ITER) begin
            r   <= nonneg ? diff : r_sh;
            qs  <= {qs[WIDTH-2:0], nonneg};
            cnt <= cnt + 1'b1;
        end else if (state_q == FIX) begin
            div_by_zero <= zero_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            ovf_q <= min_neg && !zero_d;
            if (zero_d) begin
                quotient  <= '1;
                remainder <= n_raw;
            end else if (min_neg) begin
                quotient  <= MOST_NEG;
                remainder <= '0;
            end else begin
                quotient  <= sgn_q ? -qs : qs;
                remainder <= sgn_n ? WIDTH'(-r) : WIDTH'(r);
            end
`else
            if (zero_d) begin
                quotient  <= '1;
                remainder <= n_raw;
            end else begin
                quotient  <= qs;
                remainder <= WIDTH'(r);
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider; expectations come from native
// integer division, signed or unsigned to match the build.
module tb_seq_divider;
    import divider_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sd;
        e = '0;
        sa = 0;
        sd = 0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.q  = a;
            e.r  = '0;
            e.ov = 1'b1;
        end else begin
            sa  = $signed(a);
            sd  = $signed(b);
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
        end
`else
        else begin
            e.q = a / b;
            e.r = a % b;
        end
`endif
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input bit glitch,
                          input bit poke);
        exp_t e;
        int   k;
        int   bc;
        bit   seen;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd1;
        bc   = busy ? 1 : 0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (glitch && k == 2) begin
                start    = 1'b1;
                dividend = 8'h11;
                divisor  = 8'h03;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            k++;
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            check("quot", quotient, e.q);
            check("rem", remainder, e.r);
            check("dbz", div_by_zero, e.dz);
            check("ovf", overflow, e.ov);
            check("latency", k, W + 1);
            check("busy_cycles", bc, W + 1);
            if (poke) start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
            if (poke) begin
                @(posedge clock);
                #1;
                check("start_in_done", busy, 0);
            end
        end
    endtask

    initial begin
        int dc;
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        start = 1'b0;

        run_op(8'd100, 8'd7, 1'b0, 1'b0);
        run_op(8'h9C, 8'd7, 1'b0, 1'b0);
        run_op(8'd100, 8'hF9, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0, 1'b0);
        run_op(8'd6, 8'd3, 1'b0, 1'b0);
        run_op(8'd100, 8'd7, 1'b1, 1'b0);
        run_op(8'd77, 8'd5, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom_range(1, 255)), 1'b0, 1'b0);
        end
        run_op(8'd5, 8'd0, 1'b0, 1'b0);

        @(negedge clock);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        dc = done ? 1 : 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) dc++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_ovf", overflow, 0);
        check("abort_no_done", dc, 0);

        run_op(8'd6, 8'd3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
